// File: rtl/a429_wb_host_pkg.sv
// Shared definitions for the ARINC429 Wishbone host: FSM encoding, default
// register map, status bit positions and control-register field layout.
package a429_wb_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_POLL,
    S_DECIDE,
    S_RXRD,
    S_TXWR,
    S_GAP
  } state_t;

  localparam logic [1:0] A429_ADR_CTRL = 2'd0;
  localparam logic [1:0] A429_ADR_STAT = 2'd1;
  localparam logic [1:0] A429_ADR_TXD  = 2'd2;
  localparam logic [1:0] A429_ADR_RXD  = 2'd3;

  localparam int A429_STAT_TXFL_BIT = 0;
  localparam int A429_STAT_RXET_BIT = 1;

  // Control register fields
  localparam int CTRL_TX_EN_BIT = 0;
  localparam int CTRL_RX_EN_BIT = 1;
  localparam int CTRL_TX_HI_BIT = 2;
  localparam int CTRL_RX_HI_BIT = 3;
  localparam int CTRL_LOOP_BIT  = 4;

  localparam logic [31:0] A429_CTRL_INIT = 32'h0000_000F;

endpackage

// File: rtl/a429_wb_xfer.sv
// Single-transfer Wishbone engine: registered request, ack capture and
// ack timeout; reports completion as one-cycle done/err pulses.
module a429_wb_xfer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  req_adr,
  input  logic        req_wnr,
  input  logic [31:0] req_dat,
  input  logic        ack,
  output logic        stb,
  output logic [1:0]  adr,
  output logic        wnr,
  output logic [31:0] dat,
  output logic        done,
  output logic        err
);

  localparam logic [9:0] TO_LAST = 10'(ACK_TIMEOUT - 1);

  logic [9:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb  <= 1'b0;
      adr  <= 2'd0;
      wnr  <= 1'b0;
      dat  <= 32'd0;
      done <= 1'b0;
      err  <= 1'b0;
      cnt  <= 10'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (stb) begin
        // An ack on the final counted cycle still wins over the timeout.
        if (ack) begin
          stb  <= 1'b0;
          done <= 1'b1;
        end else if (cnt == TO_LAST) begin
          stb <= 1'b0;
          err <= 1'b1;
        end else begin
          cnt <= cnt + 10'd1;
        end
      end else if (start) begin
        stb <= 1'b1;
        adr <= req_adr;
        wnr <= req_wnr;
        dat <= req_dat;
        cnt <= 10'd0;
      end
    end
  end

endmodule

// File: rtl/a429_wb_host.sv
// Autonomous Wishbone initiator: configures an ARINC429 controller, polls its
// status and moves words between local TX/RX streams and the controller FIFOs.
module a429_wb_host
  import a429_wb_host_pkg::*;
#(
  parameter logic [31:0] CTRL_INIT     = A429_CTRL_INIT,
  parameter logic [1:0]  ADR_CTRL      = A429_ADR_CTRL,
  parameter logic [1:0]  ADR_STAT      = A429_ADR_STAT,
  parameter logic [1:0]  ADR_TXD       = A429_ADR_TXD,
  parameter logic [1:0]  ADR_RXD       = A429_ADR_RXD,
  parameter int          STAT_TXFL_BIT = A429_STAT_TXFL_BIT,
  parameter int          STAT_RXET_BIT = A429_STAT_RXET_BIT,
  parameter int          POLL_GAP      = 16,
  parameter int          ACK_TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [1:0]  adr_o,
  output logic        wnr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        irq_i,
  input  logic        tx_vld_i,
  input  logic [31:0] tx_dat_i,
  output logic        tx_rdy_o,
  output logic        rx_vld_o,
  output logic [31:0] rx_dat_o,
  input  logic        rx_rdy_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_t      state;
  logic        en_q, armed, rr_tx, err_q;
  logic        hold_full, out_full, txfl, rxet;
  logic [31:0] hold_dat, out_dat;
  logic [7:0]  gap_cnt;

  logic        start, req_wnr, x_stb, x_done, x_err;
  logic [1:0]  req_adr;
  logic [31:0] req_dat;
  logic        en_rise, ack_hit, rx_ok, tx_ok, pick_rx, pick_tx, gap_end;

  assign en_rise = en_i & ~en_q;
  assign ack_hit = x_stb & ack_i;
  assign rx_ok   = ~rxet & ~out_full;
  assign tx_ok   = hold_full & ~txfl;
  assign pick_rx = rx_ok & (~tx_ok | ~rr_tx);
  assign pick_tx = tx_ok & ~pick_rx;
  assign gap_end = irq_i | (gap_cnt == GAP_LAST);

  assign cyc_o    = x_stb;
  assign stb_o    = x_stb;
  assign busy_o   = (state != S_IDLE);
  assign err_o    = err_q;
  assign tx_rdy_o = ~hold_full & en_i & armed;
  assign rx_vld_o = out_full;
  assign rx_dat_o = out_dat;

  // Requests are launched on the transition edge so stb is high in the
  // first cycle of each bus state.
  always_comb begin
    start   = 1'b0;
    req_adr = ADR_STAT;
    req_wnr = 1'b0;
    req_dat = CTRL_INIT;
    case (state)
      S_IDLE: if (en_rise) begin
        start   = 1'b1;
        req_adr = ADR_CTRL;
        req_wnr = 1'b1;
      end
      S_CFG, S_RXRD, S_TXWR: start = x_done;
      S_DECIDE: if (en_i) begin
        if (pick_rx) begin
          start   = 1'b1;
          req_adr = ADR_RXD;
        end else if (pick_tx) begin
          start   = 1'b1;
          req_adr = ADR_TXD;
          req_wnr = 1'b1;
          req_dat = hold_dat;
        end
      end
      S_GAP: start = en_i & gap_end;
      default: ;
    endcase
  end

  a429_wb_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .start   (start),
    .req_adr (req_adr),
    .req_wnr (req_wnr),
    .req_dat (req_dat),
    .ack     (ack_i),
    .stb     (x_stb),
    .adr     (adr_o),
    .wnr     (wnr_o),
    .dat     (dat_o),
    .done    (x_done),
    .err     (x_err)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      en_q    <= 1'b0;
      armed   <= 1'b0;
      rr_tx   <= 1'b0;
      err_q   <= 1'b0;
      gap_cnt <= 8'd0;
    end else begin
      en_q  <= en_i;
      armed <= 1'b1;
      if (en_rise) err_q <= 1'b0;
      if (x_err) begin
        state <= S_IDLE;
        err_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (en_rise) state <= S_CFG;
          S_CFG, S_RXRD, S_TXWR: if (x_done) state <= S_POLL;
          S_POLL: if (x_done) state <= S_DECIDE;
          S_DECIDE: begin
            if (!en_i) begin
              state <= S_IDLE;
            end else if (pick_rx) begin
              state <= S_RXRD;
              rr_tx <= 1'b1;
            end else if (pick_tx) begin
              state <= S_TXWR;
              rr_tx <= 1'b0;
            end else begin
              state   <= S_GAP;
              gap_cnt <= 8'd0;
            end
          end
          S_GAP: begin
            if (!en_i)        state   <= S_IDLE;
            else if (gap_end) state   <= S_POLL;
            else              gap_cnt <= gap_cnt + 8'd1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Local stream slots; a bus transfer on a slot and its local handshake
  // can never coincide because DECIDE only picks a slot in the opposite state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_full <= 1'b0;
      hold_dat  <= 32'd0;
      out_full  <= 1'b0;
      out_dat   <= 32'd0;
      txfl      <= 1'b0;
      rxet      <= 1'b1;
    end else begin
      if (tx_vld_i && tx_rdy_o) begin
        hold_full <= 1'b1;
        hold_dat  <= tx_dat_i;
      end else if (state == S_TXWR && ack_hit) begin
        hold_full <= 1'b0;
      end
      if (rx_vld_o && rx_rdy_i) begin
        out_full <= 1'b0;
      end else if (state == S_RXRD && ack_hit) begin
        out_full <= 1'b1;
        out_dat  <= dat_i;
      end
      if (state == S_POLL && ack_hit) begin
        txfl <= dat_i[STAT_TXFL_BIT];
        rxet <= dat_i[STAT_RXET_BIT];
      end
    end
  end

endmodule
